// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - RV32IC control-flow decode types and immediate helpers for the branch predictor.
package bp_pkg;

  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JAL    = 7'h6F;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;

  localparam logic [2:0] C_F3_J    = 3'b101;
  localparam logic [2:0] C_F3_JAL  = 3'b001;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;
  localparam logic [2:0] C_F3_JR   = 3'b100;

  typedef enum logic [2:0] {
    CF_NONE,
    CF_B,
    CF_JAL,
    CF_JALR,
    CF_CJ,
    CF_CB,
    CF_CJR
  } instr_class_e;

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_cj(input logic [31:0] i);
    return {{21{i[12]}}, i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
  endfunction

  function automatic logic [31:0] imm_cb(input logic [31:0] i);
    return {{24{i[12]}}, i[6:5], i[2], i[11:10], i[4:3], 1'b0};
  endfunction

  function automatic instr_class_e classify(input logic [31:0] i);
    instr_class_e c;
    c = CF_NONE;
    if (i[1:0] == 2'b11) begin
      if (i[6:0] == OPCODE_BRANCH)    c = CF_B;
      else if (i[6:0] == OPCODE_JAL)  c = CF_JAL;
      else if (i[6:0] == OPCODE_JALR) c = CF_JALR;
    end else if (i[1:0] == 2'b01) begin
      if (i[15:13] == C_F3_J || i[15:13] == C_F3_JAL)          c = CF_CJ;
      else if (i[15:13] == C_F3_BEQZ || i[15:13] == C_F3_BNEZ) c = CF_CB;
    end else if (i[1:0] == 2'b10) begin
      // rs1 != 0 excludes c.ebreak, which shares the funct3 with c.jr/c.jalr
      if (i[15:13] == C_F3_JR && i[11:7] != 5'd0 && i[6:2] == 5'd0) c = CF_CJR;
    end
    return c;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// rtl/bp_btb.sv - Direct-mapped indirect-jump target buffer with flush.
module bp_btb #(
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] rd_pc_i,
  output logic        rd_hit_o,
  output logic [31:0] rd_target_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_pc_i,
  input  logic [31:0] wr_target_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];

  logic [IDX_W-1:0]    w_rd_idx;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [TAG_BITS-1:0] w_rd_tag;
  logic [TAG_BITS-1:0] w_wr_tag;
  logic                w_wr_ok;
  logic                w_unused_pc;

  assign w_rd_idx    = rd_pc_i[IDX_W:1];
  assign w_wr_idx    = wr_pc_i[IDX_W:1];
  assign w_rd_tag    = rd_pc_i[IDX_W+TAG_BITS:IDX_W+1];
  assign w_wr_tag    = wr_pc_i[IDX_W+TAG_BITS:IDX_W+1];
  assign w_unused_pc = ^{rd_pc_i, wr_pc_i};

  // Flush outranks a same-cycle write so a stale context can never install a target
  assign w_wr_ok = wr_en_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_valid <= '0;
    end else if (w_wr_ok) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr_ok) begin
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= wr_target_i;
    end
  end

  assign rd_hit_o    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign rd_target_o = r_target[w_rd_idx];

endmodule

// File: rtl/dyn_branch_predict.sv
// rtl/dyn_branch_predict.sv - Bimodal conditional-branch predictor with BTB for indirect jumps.
module dyn_branch_predict
  import bp_pkg::*;
#(
  parameter int BHT_ENTRIES  = 64,
  parameter int CTR_BITS     = 2,
  parameter int BTB_ENTRIES  = 16,
  parameter int BTB_TAG_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_valid_i,
  output logic        predict_branch_taken_o,
  output logic [31:0] predict_branch_pc_o,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_branch_i,
  input  logic        update_jalr_i,
  input  logic        update_taken_i,
  input  logic [31:0] update_target_i,
  input  logic        flush_i
);

  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  logic [CTR_BITS-1:0]  r_bht [BHT_ENTRIES];

  instr_class_e         w_class;
  logic [BHT_IDX_W-1:0] w_fetch_idx;
  logic [BHT_IDX_W-1:0] w_upd_idx;
  logic [CTR_BITS-1:0]  w_upd_ctr;
  logic                 w_btb_hit;
  logic [31:0]          w_btb_target;
  logic                 w_taken;
  logic [31:0]          w_target;

  assign w_class     = classify(fetch_rdata_i);
  assign w_fetch_idx = fetch_pc_i[BHT_IDX_W:1];
  assign w_upd_idx   = update_pc_i[BHT_IDX_W:1];
  assign w_upd_ctr   = r_bht[w_upd_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_INIT;
    end else if (update_valid_i && update_branch_i) begin
      if (update_taken_i && w_upd_ctr != CTR_MAX) begin
        r_bht[w_upd_idx] <= w_upd_ctr + CTR_BITS'(1);
      end else if (!update_taken_i && w_upd_ctr != '0) begin
        r_bht[w_upd_idx] <= w_upd_ctr - CTR_BITS'(1);
      end
    end
  end

  bp_btb #(
    .ENTRIES  (BTB_ENTRIES),
    .TAG_BITS (BTB_TAG_BITS)
  ) u_btb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .rd_pc_i     (fetch_pc_i),
    .rd_hit_o    (w_btb_hit),
    .rd_target_o (w_btb_target),
    .wr_en_i     (update_valid_i && update_jalr_i && update_taken_i),
    .wr_pc_i     (update_pc_i),
    .wr_target_i (update_target_i)
  );

  always_comb begin
    w_taken  = 1'b0;
    w_target = fetch_pc_i + imm_b(fetch_rdata_i);
    unique case (w_class)
      CF_B: begin
        w_taken  = r_bht[w_fetch_idx][CTR_BITS-1];
        w_target = fetch_pc_i + imm_b(fetch_rdata_i);
      end
      CF_CB: begin
        w_taken  = r_bht[w_fetch_idx][CTR_BITS-1];
        w_target = fetch_pc_i + imm_cb(fetch_rdata_i);
      end
      CF_JAL: begin
        w_taken  = 1'b1;
        w_target = fetch_pc_i + imm_j(fetch_rdata_i);
      end
      CF_CJ: begin
        w_taken  = 1'b1;
        w_target = fetch_pc_i + imm_cj(fetch_rdata_i);
      end
      CF_JALR, CF_CJR: begin
        w_taken  = w_btb_hit;
        w_target = w_btb_target;
      end
      default: ;
    endcase
  end

  assign predict_branch_taken_o = !rst_i && w_taken && fetch_valid_i;
  assign predict_branch_pc_o    = rst_i ? fetch_pc_i : w_target;

endmodule

// File: tb/tb_dyn_branch_predict.sv
// tb/tb_dyn_branch_predict.sv - Self-checking bench for dyn_branch_predict.
module tb_dyn_branch_predict;

  localparam int BHT_N  = 64;
  localparam int CTR_B  = 2;
  localparam int BTB_N  = 16;
  localparam int TAG_B  = 8;
  localparam int TAG_SH = 1 + $clog2(BTB_N);
  localparam int CTR_HI = (1 << CTR_B) - 1;
  localparam int CTR_TH = 1 << (CTR_B - 1);

  localparam logic [31:0] BEQ_M8  = 32'hFE000CE3;
  localparam logic [31:0] JAL_P8  = 32'h0080006F;
  localparam logic [31:0] RET     = 32'h00008067;
  localparam logic [31:0] C_JR_RA = 32'h00008082;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_valid_i;
  logic        predict_branch_taken_o;
  logic [31:0] predict_branch_pc_o;
  logic        update_valid_i;
  logic [31:0] update_pc_i;
  logic        update_branch_i;
  logic        update_jalr_i;
  logic        update_taken_i;
  logic [31:0] update_target_i;
  logic        flush_i;

  int checks = 0;
  int errors = 0;

  int          m_cnt [BHT_N];
  bit          m_val [BTB_N];
  int          m_tag [BTB_N];
  logic [31:0] m_tgt [BTB_N];

  always #5 clk = ~clk;

  dyn_branch_predict #(
    .BHT_ENTRIES  (BHT_N),
    .CTR_BITS     (CTR_B),
    .BTB_ENTRIES  (BTB_N),
    .BTB_TAG_BITS (TAG_B)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .fetch_rdata_i          (fetch_rdata_i),
    .fetch_pc_i             (fetch_pc_i),
    .fetch_valid_i          (fetch_valid_i),
    .predict_branch_taken_o (predict_branch_taken_o),
    .predict_branch_pc_o    (predict_branch_pc_o),
    .update_valid_i         (update_valid_i),
    .update_pc_i            (update_pc_i),
    .update_branch_i        (update_branch_i),
    .update_jalr_i          (update_jalr_i),
    .update_taken_i         (update_taken_i),
    .update_target_i        (update_target_i),
    .flush_i                (flush_i)
  );

  function automatic int bht_idx(input logic [31:0] pc);
    return int'((pc >> 1) % BHT_N);
  endfunction

  function automatic int btb_idx(input logic [31:0] pc);
    return int'((pc >> 1) % BTB_N);
  endfunction

  function automatic int btb_tag(input logic [31:0] pc);
    return int'((pc >> TAG_SH) % (1 << TAG_B));
  endfunction

  // Reference training: saturating counters and a last-writer-wins target table
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_N; i++) m_cnt[i] = CTR_TH - 1;
      for (int i = 0; i < BTB_N; i++) m_val[i] = 1'b0;
    end else begin
      if (update_valid_i && update_branch_i) begin
        if (update_taken_i) m_cnt[bht_idx(update_pc_i)] = (m_cnt[bht_idx(update_pc_i)] < CTR_HI) ? m_cnt[bht_idx(update_pc_i)] + 1 : CTR_HI;
        else                m_cnt[bht_idx(update_pc_i)] = (m_cnt[bht_idx(update_pc_i)] > 0) ? m_cnt[bht_idx(update_pc_i)] - 1 : 0;
      end
      if (flush_i) begin
        for (int i = 0; i < BTB_N; i++) m_val[i] = 1'b0;
      end else if (update_valid_i && update_jalr_i && update_taken_i) begin
        m_val[btb_idx(update_pc_i)] = 1'b1;
        m_tag[btb_idx(update_pc_i)] = btb_tag(update_pc_i);
        m_tgt[btb_idx(update_pc_i)] = update_target_i;
      end
    end
  end

  // Expected prediction from the instruction fields, offsets rebuilt as signed sums
  function automatic void model_predict(output bit tk, output logic [31:0] pc);
    logic [31:0] i;
    int kind;
    int off;
    i    = fetch_rdata_i;
    kind = 0;
    off  = 0;
    if (i[1:0] == 2'b11 && i[6:0] == 7'h63) begin
      kind = 1;
      off  = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    end else if (i[1:0] == 2'b11 && i[6:0] == 7'h6F) begin
      kind = 2;
      off  = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    end else if (i[1:0] == 2'b11 && i[6:0] == 7'h67) begin
      kind = 3;
    end else if (i[1:0] == 2'b01 && (i[15:13] == 3'd5 || i[15:13] == 3'd1)) begin
      kind = 2;
      off  = (i[12] ? -2048 : 0) + int'(i[8]) * 1024 + int'(i[10:9]) * 256 + int'(i[6]) * 128
           + int'(i[7]) * 64 + int'(i[2]) * 32 + int'(i[11]) * 16 + int'(i[5:3]) * 2;
    end else if (i[1:0] == 2'b01 && (i[15:13] == 3'd6 || i[15:13] == 3'd7)) begin
      kind = 1;
      off  = (i[12] ? -256 : 0) + int'(i[6:5]) * 64 + int'(i[2]) * 32 + int'(i[11:10]) * 8 + int'(i[4:3]) * 2;
    end else if (i[1:0] == 2'b10 && i[15:13] == 3'd4 && i[11:7] != 5'd0 && i[6:2] == 5'd0) begin
      kind = 3;
    end
    tk = 1'b0;
    pc = fetch_pc_i + 32'(off);
    case (kind)
      1: tk = (m_cnt[bht_idx(fetch_pc_i)] >= CTR_TH);
      2: tk = 1'b1;
      3: begin
        tk = m_val[btb_idx(fetch_pc_i)] && (m_tag[btb_idx(fetch_pc_i)] == btb_tag(fetch_pc_i));
        pc = m_tgt[btb_idx(fetch_pc_i)];
      end
      default: ;
    endcase
    tk = tk && fetch_valid_i;
    if (rst_i) begin
      tk = 1'b0;
      pc = fetch_pc_i;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample(input string tag, input bit tk, input logic [31:0] pc, input bit chk_pc);
    @(negedge clk);
    check({tag, "_taken"}, 32'(predict_branch_taken_o), 32'(tk));
    if (chk_pc) check({tag, "_pc"}, predict_branch_pc_o, pc);
  endtask

  task automatic sample_model(input string tag);
    bit          tk;
    logic [31:0] pc;
    @(negedge clk);
    model_predict(tk, pc);
    check({tag, "_taken"}, 32'(predict_branch_taken_o), 32'(tk));
    if (tk || rst_i) check({tag, "_pc"}, predict_branch_pc_o, pc);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    rst_i          = 1'b0;
    update_valid_i = 1'b0;
    update_branch_i = 1'b0;
    update_jalr_i  = 1'b0;
    update_taken_i = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc, input bit v);
    fetch_rdata_i = ins;
    fetch_pc_i    = pc;
    fetch_valid_i = v;
  endtask

  task automatic upd(input logic [31:0] pc, input bit br, input bit jr, input bit tk, input logic [31:0] tgt);
    update_valid_i  = 1'b1;
    update_pc_i     = pc;
    update_branch_i = br;
    update_jalr_i   = jr;
    update_taken_i  = tk;
    update_target_i = tgt;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom & 32'h0000_01FE;
    if ($urandom_range(0, 7) == 0) p = p | ($urandom & 32'hFFFF_FE00);
    return p;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: w = {w[31:7], 7'h63};
      1: w = {w[31:7], 7'h6F};
      2: w = {w[31:7], 7'h67};
      3: w = {w[31:16], ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b001, w[12:2], 2'b01};
      4: w = {w[31:16], 2'b11, w[13], w[12:2], 2'b01};
      5: w = {w[31:16], 3'b100, w[12], (w[11:7] == 5'd0) ? 5'd1 : w[11:7], 5'd0, 2'b10};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst_i = 1'b0; flush_i = 1'b0;
    update_valid_i = 1'b0; update_pc_i = '0; update_branch_i = 1'b0;
    update_jalr_i = 1'b0; update_taken_i = 1'b0; update_target_i = '0;
    fetch(BEQ_M8, 32'h100, 1'b1);
    next();

    rst_i = 1'b1;
    sample("rst_out", 1'b0, 32'h100, 1'b1);
    next();
    sample("b_weak_nt", 1'b0, 32'h0, 1'b0);
    next();
    fetch_valid_i = 1'b0;
    sample("b_novalid", 1'b0, 32'h0, 1'b0);

    next();
    fetch_valid_i = 1'b1;
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h0);
    next();
    sample("b_trained", 1'b1, 32'h0F8, 1'b1);
    for (int k = 0; k < 4; k++) begin
      next();
      upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
      next();
      sample("b_nt_train", 1'b0, 32'h0, 1'b0);
    end
    next();
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h0);
    next();
    sample("b_from_zero", 1'b0, 32'h0, 1'b0);
    next();
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h0);
    next();
    sample("b_sat_low", 1'b1, 32'h0F8, 1'b1);

    next();
    rst_i = 1'b1;
    next();
    fetch(JAL_P8, 32'h200, 1'b1);
    sample("jal", 1'b1, 32'h208, 1'b1);
    next();
    fetch_valid_i = 1'b0;
    sample("jal_novalid", 1'b0, 32'h0, 1'b0);
    next();
    fetch_valid_i = 1'b1;
    rst_i = 1'b1;
    sample("jal_in_rst", 1'b0, 32'h200, 1'b1);

    next();
    fetch(RET, 32'h300, 1'b1);
    sample("jalr_miss", 1'b0, 32'h0, 1'b0);
    next();
    upd(32'h300, 1'b0, 1'b1, 1'b1, 32'h1234);
    sample("jalr_wr_cycle", 1'b0, 32'h0, 1'b0);
    next();
    sample("jalr_hit", 1'b1, 32'h1234, 1'b1);
    next();
    fetch(C_JR_RA, 32'h300, 1'b1);
    sample("cjr_hit", 1'b1, 32'h1234, 1'b1);
    next();
    fetch(RET, 32'h300 + 2 * BTB_N, 1'b1);
    sample("jalr_alias", 1'b0, 32'h0, 1'b0);
    next();
    upd(32'h300, 1'b0, 1'b1, 1'b0, 32'h5555);
    next();
    fetch(RET, 32'h300, 1'b1);
    sample("jalr_nt_keep", 1'b1, 32'h1234, 1'b1);
    next();
    flush_i = 1'b1;
    next();
    sample("jalr_flushed", 1'b0, 32'h0, 1'b0);

    next();
    rst_i = 1'b1;
    next();
    fetch(BEQ_M8, 32'h100, 1'b1);
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h0);
    sample("same_cycle_pre", 1'b0, 32'h0, 1'b0);
    next();
    sample("same_cycle_post", 1'b1, 32'h0F8, 1'b1);
    next();
    fetch(RET, 32'h300, 1'b1);
    flush_i = 1'b1;
    upd(32'h300, 1'b0, 1'b1, 1'b1, 32'h4444);
    next();
    sample("flush_wins", 1'b0, 32'h0, 1'b0);

    next();
    upd(32'h300, 1'b0, 1'b1, 1'b1, 32'h8888);
    next();
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h0);
    sample("pre_rst_hit", 1'b1, 32'h8888, 1'b1);
    next();
    rst_i = 1'b1;
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h0);
    next();
    fetch(BEQ_M8, 32'h100, 1'b1);
    sample("post_rst_b", 1'b0, 32'h0, 1'b0);
    next();
    fetch(RET, 32'h300, 1'b1);
    sample("post_rst_btb", 1'b0, 32'h0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      next();
      fetch(rand_instr(), rand_pc(), ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 1) == 1) begin
        upd(rand_pc(), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1), $urandom);
      end
      flush_i = ($urandom_range(0, 15) == 0);
      rst_i   = ($urandom_range(0, 63) == 0);
      sample_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dyn_branch_predict.md
Name: dyn_branch_predict

Overview:
Fetch-stage branch predictor that replaces the static backward-taken rule with a trained bimodal predictor. It decodes the same RV32IC control-flow classes as the existing static predictor. Conditional branches are predicted from a table of saturating counters. Indirect jumps (JALR, C.JR, C.JALR) are predicted from a direct-mapped BTB rather than a supplied register value. Tables are trained by execute-stage resolution feedback; the prediction path stays combinational so fetch timing is unchanged.

Parameters:
BHT_ENTRIES, 64, number of counters; power of 2, ≥2.
CTR_BITS, 2, counter width; 1..4.
BTB_ENTRIES, 16, number of indirect-target entries; power of 2, ≥2.
BTB_TAG_BITS, 8, stored PC tag bits per BTB entry.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous active-high reset.
fetch_rdata_i  in  32  fetched instruction; compressed instructions occupy [15:0].
fetch_pc_i  in  32  PC of the fetched instruction.
fetch_valid_i  in  1  fetch_rdata_i/fetch_pc_i are valid.
predict_branch_taken_o  out  1  predict redirect.
predict_branch_pc_o  out  32  predicted target.
update_valid_i  in  1  resolution from execute.
update_pc_i  in  32  PC of the resolved instruction.
update_branch_i  in  1  resolved instruction is a conditional branch (B or CB).
update_jalr_i  in  1  resolved instruction is an indirect jump.
update_taken_i  in  1  actual outcome.
update_target_i  in  32  actual target.
flush_i  in  1  invalidate all BTB entries (context switch or fence).

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset, after one rst_i cycle:
  - every counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 2'b01 at the default width);
  - all BTB valid bits = 0.
  - While rst_i=1, predict_branch_taken_o=0 and predict_branch_pc_o=fetch_pc_i.
- Decode (combinational). Uncompressed forms require [1:0]=11:
  - B: opcode 0x63.
  - JAL: opcode 0x6F.
  - JALR: opcode 0x67.
  - CJ: quadrant 01, funct3 101 or 001.
  - CB: quadrant 01, funct3 110 or 111.
  - CJR: quadrant 10, funct3 100, rs1≠0, rs2=0.
- Immediates: sign-extended to 32 bits with the standard RV32IC B/J/CJ/CB layouts.
- Index and tag fields:
  - BHT index = fetch_pc_i[log2(BHT_ENTRIES):1].
  - BTB index = pc[log2(BTB_ENTRIES):1].
  - BTB tag = the next BTB_TAG_BITS PC bits above the index.
- Prediction (zero latency, combinational from fetch inputs and current table state):
  - JAL, CJ: always taken; target = fetch_pc_i + imm.
  - B, CB: taken iff the indexed counter MSB = 1; target = fetch_pc_i + imm.
  - JALR, CJR: taken iff the BTB entry is valid and its tag matches; target = stored target.
  - Other instructions: not taken; predict_branch_pc_o = fetch_pc_i + imm_b.
  - The pc output is don't-care for verification when not taken.
  - All adds wrap modulo 2^32.
  - predict_branch_taken_o is ANDed with fetch_valid_i.
- Training (registered; visible to a lookup the cycle after update_valid_i):
  - update_valid_i & update_branch_i: counter at the update_pc_i index increments if taken, decrements if not. It saturates at 2^CTR_BITS-1 and at 0.
  - update_valid_i & update_jalr_i & update_taken_i: write the BTB entry with valid=1, tag, and update_target_i. An existing entry is replaced unconditionally.
  - update_jalr_i with not-taken does not change the BTB.
- Simultaneous events:
  - Lookup and update to the same index in one cycle: the lookup uses the pre-update value. There is no bypass.
  - flush_i together with a BTB write: flush wins and the write is dropped. Counters are unaffected by flush_i.
  - update_branch_i and update_jalr_i both high: illegal. The design applies both updates and does not assert.
  - rst_i during training: reset overrides every update in that cycle.

Decomposition:
- Package bp_pkg holds:
  - opcode and compressed funct3 localparams (OPCODE_BRANCH 7'h63, OPCODE_JAL 7'h6F, OPCODE_JALR 7'h67);
  - enum instr_class_e {CF_NONE, CF_B, CF_JAL, CF_JALR, CF_CJ, CF_CB, CF_CJR};
  - immediate-extraction functions.
- Sub-module bp_btb: direct-mapped tag/target/valid storage with read port, write port, and flush. The counter table stays inline.

Test Plan:
1. Reset, then fetch 0xFE000CE3 (beq x0,x0,-8) at pc 0x100 with fetch_valid_i=1 -> taken=0. Repeat with fetch_valid_i=0 -> taken=0.
2. One taken update of B at pc 0x100 -> next-cycle fetch of 0xFE000CE3 gives taken=1, pc=0x0F8. Three not-taken updates -> counter 0. A fourth not-taken update stays at 0. Then one taken update -> counter 1, taken=0.
3. Fetch 0x0080006F (jal x0,+8) at pc 0x200 on a fresh reset -> taken=1, pc=0x208. Apply rst_i for one cycle while fetching it -> taken=0.
4. Fetch 0x00008067 (ret) at pc 0x300 -> taken=0. After a JALR taken update (pc 0x300, target 0x1234) -> taken=1, pc=0x1234. Fetch at pc 0x300 + 2·BTB_ENTRIES (aliasing index, different tag) -> taken=0. flush_i -> pc 0x300 gives taken=0.
5. In the same cycle: fetch B at pc 0x100 and a taken update to pc 0x100 (counter at 1) -> that cycle taken=0, next cycle taken=1. flush_i plus a JALR update in the same cycle -> entry remains invalid.
6. With a trained table, apply rst_i mid-stream -> after reset, B at 0x100 gives taken=0 and the BTB misses.
